// File: rtl/dco_freq_lock_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dco_flc_if
// Brief    : Control/status bundle between the DCO frequency-lock loop and
//            its configuration/observation side.
// Revision : 1.0 - initial release
// ============================================================================
interface dco_flc_if #(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 10,
  parameter int LOCK_W = 4
);
  logic                    enable;
  logic [CNT_W-1:0]        dcoCount;
  logic [CNT_W-1:0]        targetCount;
  logic [WIN_W-1:0]        windowCycles;
  logic [CNT_W-1:0]        tolerance;
  logic [LOCK_W-1:0]       lockThresh;
  logic                    inc;
  logic                    dec;
  logic                    locked;
  logic signed [CNT_W:0]   freqError;
  logic                    errorValid;

  modport master (
    output enable, dcoCount, targetCount, windowCycles, tolerance, lockThresh,
    input  inc, dec, locked, freqError, errorValid
  );

  modport slave (
    input  enable, dcoCount, targetCount, windowCycles, tolerance, lockThresh,
    output inc, dec, locked, freqError, errorValid
  );
endinterface
`default_nettype wire

// File: rtl/dco_freq_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dco_freq_lock_ctrl
// Brief    : Windowed DCO frequency measurement, inc/dec step bursts toward
//            the thermometer shifter, and lock tracking.
// Revision : 1.0 - initial release
// ============================================================================
module dco_freq_lock_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 10,
  parameter int LOCK_W     = 4,
  parameter int MAX_STEPS  = 8,
  parameter int GAIN_SHIFT = 2
) (
  input  logic      clock,
  input  logic      reset,
  dco_flc_if.slave  bus
);

  localparam int                c_step_w    = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W:0]    c_max_ext   = (CNT_W + 1)'(MAX_STEPS);
  localparam logic [c_step_w-1:0] c_max_steps = c_step_w'(MAX_STEPS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_EVAL    = 2'd2,
    S_STEP    = 2'd3
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [CNT_W-1:0]    r_ref,       w_ref_nxt;
  logic [WIN_W-1:0]    r_win,       w_win_nxt;
  logic [LOCK_W-1:0]   r_lock_cnt,  w_lock_cnt_nxt;
  logic [c_step_w-1:0] r_steps,     w_steps_nxt;
  logic                r_inc,       w_inc_nxt;
  logic                r_dec,       w_dec_nxt;
  logic                r_locked,    w_locked_nxt;
  logic                r_err_valid, w_err_valid_nxt;
  logic [CNT_W:0]      r_freq_err,  w_freq_err_nxt;

  logic [WIN_W-1:0]    w_win_len;
  logic [CNT_W-1:0]    w_delta;
  logic [CNT_W:0]      w_err_meas;
  logic [CNT_W:0]      w_abs;
  logic [CNT_W:0]      w_shifted;
  logic [c_step_w-1:0] w_burst;
  logic                w_in_band;
  logic [LOCK_W-1:0]   w_lock_inc;

  assign w_win_len  = (bus.windowCycles == '0) ? WIN_W'(1) : bus.windowCycles;
  // Modular subtraction absorbs counter wrap inside a window.
  assign w_delta    = bus.dcoCount - r_ref;
  assign w_err_meas = {1'b0, w_delta} - {1'b0, bus.targetCount};
  assign w_abs      = r_freq_err[CNT_W] ? (~r_freq_err + (CNT_W + 1)'(1)) : r_freq_err;
  assign w_shifted  = w_abs >> GAIN_SHIFT;
  assign w_burst    = (w_shifted == '0)       ? c_step_w'(1) :
                      (w_shifted > c_max_ext) ? c_max_steps  :
                                                w_shifted[c_step_w-1:0];
  assign w_in_band  = (w_abs <= {1'b0, bus.tolerance});
  assign w_lock_inc = (&r_lock_cnt) ? r_lock_cnt : r_lock_cnt + LOCK_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_ref_nxt       = r_ref;
    w_win_nxt       = r_win;
    w_lock_cnt_nxt  = r_lock_cnt;
    w_steps_nxt     = r_steps;
    w_inc_nxt       = r_inc;
    w_dec_nxt       = r_dec;
    w_locked_nxt    = r_locked;
    w_err_valid_nxt = 1'b0;
    w_freq_err_nxt  = r_freq_err;

    if (!bus.enable) begin
      w_state_nxt    = S_IDLE;
      w_inc_nxt      = 1'b0;
      w_dec_nxt      = 1'b0;
      w_locked_nxt   = 1'b0;
      w_lock_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_ref_nxt   = bus.dcoCount;
          w_win_nxt   = WIN_W'(1);
          w_state_nxt = S_MEASURE;
        end
        S_MEASURE: begin
          // >= so a window shortened mid-flight still terminates promptly.
          if (r_win >= w_win_len) begin
            w_freq_err_nxt  = w_err_meas;
            w_err_valid_nxt = 1'b1;
            w_state_nxt     = S_EVAL;
          end else begin
            w_win_nxt = r_win + WIN_W'(1);
          end
        end
        S_EVAL: begin
          if (w_in_band) begin
            w_lock_cnt_nxt = w_lock_inc;
            w_locked_nxt   = (w_lock_inc >= bus.lockThresh);
            w_ref_nxt      = bus.dcoCount;
            w_win_nxt      = WIN_W'(1);
            w_state_nxt    = S_MEASURE;
          end else begin
            w_lock_cnt_nxt = '0;
            w_locked_nxt   = 1'b0;
            w_steps_nxt    = w_burst;
            w_dec_nxt      = ~r_freq_err[CNT_W];
            w_inc_nxt      = r_freq_err[CNT_W];
            w_state_nxt    = S_STEP;
          end
        end
        S_STEP: begin
          if (r_steps <= c_step_w'(1)) begin
            w_inc_nxt   = 1'b0;
            w_dec_nxt   = 1'b0;
            w_ref_nxt   = bus.dcoCount;
            w_win_nxt   = WIN_W'(1);
            w_state_nxt = S_MEASURE;
          end else begin
            w_steps_nxt = r_steps - c_step_w'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ref       <= '0;
      r_win       <= '0;
      r_lock_cnt  <= '0;
      r_steps     <= '0;
      r_inc       <= 1'b0;
      r_dec       <= 1'b0;
      r_locked    <= 1'b0;
      r_err_valid <= 1'b0;
      r_freq_err  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ref       <= w_ref_nxt;
      r_win       <= w_win_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_steps     <= w_steps_nxt;
      r_inc       <= w_inc_nxt;
      r_dec       <= w_dec_nxt;
      r_locked    <= w_locked_nxt;
      r_err_valid <= w_err_valid_nxt;
      r_freq_err  <= w_freq_err_nxt;
    end
  end

  assign bus.inc        = r_inc;
  assign bus.dec        = r_dec;
  assign bus.locked     = r_locked;
  assign bus.errorValid = r_err_valid;
  assign bus.freqError  = r_freq_err;

endmodule
`default_nettype wire
